l1_dm_cache: RTL and testbench
==============================

Name: l1_dm_cache

Overview:
Parametrised direct-mapped, write-through, no-write-allocate L1 cache with a real miss state machine. It replaces the flat zero-latency memory model on the data side of the core. The CPU side keeps the existing access/we/wait semantics. The backing side is a word-wide request/ack port to the next level: a memory model with variable ack latency. Read misses refill a full line as a burst of single-word requests, and cpu_wait is driven from real hit/miss state.

Parameters:
ADDR_WIDTH, 32, byte-address width on both sides.
NUM_SETS, 64, number of lines; power of 2, >=2; index bits IW = log2(NUM_SETS).
WORDS_PER_LINE, 4, 32-bit words per line; power of 2, >=2; offset bits OW = log2(WORDS_PER_LINE).
Tag width TW = ADDR_WIDTH - IW - OW - 2.

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high
cpu_access  input  1  CPU request valid (same meaning as Dmemaccess)
cpu_we  input  1  CPU write
cpu_addr  input  ADDR_WIDTH  byte address; bits [1:0] ignored
cpu_wdata  input  32  write data
cpu_rdata  output  32  read data; 0 when cpu_access=0
cpu_wait  output  1  stall CPU this cycle
mem_req  output  1  backing request; held until mem_ack
mem_we  output  1  backing write
mem_addr  output  ADDR_WIDTH  word-aligned backing address
mem_wdata  output  32  backing write data
mem_rdata  input  32  backing read data; valid with mem_ack
mem_ack  input  1  one-cycle completion of the current mem_req

Behaviour:
- Clock is clk. Reset is asynchronous and active-high on reset.
- Reset values:
  - state=IDLE; all valid bits=0; word counter=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_wait follows IDLE rules.
  - Tag and data arrays are not reset.
- Address split: tag=addr[ADDR_WIDTH-1 -: TW], index=addr[OW+IW+1:OW+2], word=addr[OW+1:2].
- hit = valid[index] && tag_arr[index]==tag.
- State IDLE:
  - cpu_access=0: cpu_wait=0, cpu_rdata=0, no action.
  - Read hit: cpu_rdata=data[index][word] combinationally; cpu_wait=0; zero added latency.
  - Read miss: cpu_wait=1. Latch line address {tag,index}, latch word-aligned cpu_addr/cpu_wdata. Clear valid[index], cnt=0, go REFILL.
  - Write (hit or miss): cpu_wait=1. Latch addr/wdata, go WRITE.
- State REFILL:
  - mem_req=1, mem_we=0, mem_addr={ltag,lindex,cnt,2'b00}; cpu_wait=1.
  - On mem_ack: data[lindex][cnt]<=mem_rdata, cnt++.
  - On mem_ack with cnt==WORDS_PER_LINE-1: tag_arr<=ltag, valid<=1, cnt<=0, go IDLE.
  - The next cycle is a hit. Read-miss latency = WORDS_PER_LINE backing transfers + 1 cycle.
- State WRITE:
  - mem_req=1, mem_we=1, mem_addr=latched addr, mem_wdata=latched data.
  - cpu_wait = !mem_ack.
  - On mem_ack: if the latched address hits, update that data word (write-through); on a miss, no allocate. Go IDLE.
  - The CPU advances on the ack cycle, so the write is never reissued.
- mem_req is never dropped before mem_ack. mem_addr, mem_we and mem_wdata are stable while mem_req=1. mem_ack outside REFILL/WRITE is ignored.
- CPU inputs are ignored outside IDLE. The CPU holds its request while cpu_wait=1.
- A conflict miss overwrites the line; there are no dirty lines, so there is no writeback.
- Reset mid-REFILL:
  - mem_req drops immediately; the state returns to IDLE.
  - The partially refilled line stays invalid, because valid is set only on the final word.
- Reset mid-WRITE: the write is abandoned and the array is unchanged.
- A simultaneous mem_ack and reset: reset wins.
- Counter wrap: cnt is OW bits and returns to 0 after the final word. No other wrap exists.

Test Plan:
1. Cold read of 0x0000_0104, 4 words/line, backing returns addr^0xA5A5_0000 with 2-cycle ack latency:
   - mem_addr sequence is 0x100, 0x104, 0x108, 0x10C.
   - cpu_wait is high 9 cycles, then cpu_rdata=0xA5A5_0104.
2. After test 1, read 0x0000_0108: hit, cpu_wait=0 the same cycle, cpu_rdata=0xA5A5_0108, mem_req stays 0.
3. Write 0xDEAD_BEEF to 0x104 (hit):
   - One mem_req with mem_we=1, mem_addr=0x104; cpu_wait deasserts on the ack cycle.
   - A subsequent read of 0x104 hits and returns 0xDEAD_BEEF.
4. Write 0x1234_5678 to 0x2000 (miss, cold): backing write issued; a subsequent read of 0x2000 still misses and refills.
5. Conflict: read 0x104, then 0x104 + NUM_SETS*16 (0x504):
   - The second read refills and evicts the first line.
   - Rereading 0x104 misses again.
6. Assert reset after 2 refill acks:
   - mem_req=0 immediately.
   - A read of the same address after reset misses and performs a full 4-word refill.

Source files
------------

// File: rtl/l1_dm_cache_if.sv
// CPU-side and backing-side signal bundle for the L1 data cache.
// slave: the cache's view; master: the core plus next-level memory.
interface l1_dm_cache_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  cpu_access;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [31:0]           cpu_wdata;
  logic [31:0]           cpu_rdata;
  logic                  cpu_wait;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_ack;

  modport slave (
    input  cpu_access, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_wait, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_access, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_wait, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/l1_dm_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
// Read misses refill a whole line word by word; writes always go to memory.
module l1_dm_cache #(
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_SETS       = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic          clk,
  input  logic          reset,
  l1_dm_cache_if.slave  bus
);
  localparam int IW = $clog2(NUM_SETS);
  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int TW = ADDR_WIDTH - IW - OW - 2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REFILL = 2'd1;
  localparam logic [1:0] WRITE  = 2'd2;

  logic [1:0]          state;
  logic [NUM_SETS-1:0] valid;
  logic [TW-1:0]       tag_arr  [NUM_SETS];
  logic [31:0]         data_arr [NUM_SETS*WORDS_PER_LINE];
  logic [OW-1:0]       cnt;

  logic [TW-1:0] l_tag;
  logic [IW-1:0] l_idx;
  logic [OW-1:0] l_word;
  logic [31:0]   l_wdata;

  logic [TW-1:0] c_tag;
  logic [IW-1:0] c_idx;
  logic [OW-1:0] c_word;
  logic          c_hit;
  logic          l_hit;
  logic          last_word;
  logic          unused_addr_bits;

  assign c_tag            = bus.cpu_addr[ADDR_WIDTH-1 -: TW];
  assign c_idx            = bus.cpu_addr[OW+IW+1:OW+2];
  assign c_word           = bus.cpu_addr[OW+1:2];
  assign c_hit            = valid[c_idx] && (tag_arr[c_idx] == c_tag);
  assign l_hit            = valid[l_idx] && (tag_arr[l_idx] == l_tag);
  assign last_word        = (cnt == OW'(WORDS_PER_LINE - 1));
  assign unused_addr_bits = ^bus.cpu_addr[1:0];

  // Control state: FSM, valid bits, refill counter and the latched request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      valid   <= '0;
      cnt     <= '0;
      l_tag   <= '0;
      l_idx   <= '0;
      l_word  <= '0;
      l_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_access) begin
            l_tag   <= c_tag;
            l_idx   <= c_idx;
            l_word  <= c_word;
            l_wdata <= bus.cpu_wdata;
            if (bus.cpu_we) begin
              state <= WRITE;
            end else if (!c_hit) begin
              // The line is invalid from the first refill word onward, so an
              // interrupted refill can never leave a half-filled valid line.
              valid[c_idx] <= 1'b0;
              cnt          <= '0;
              state        <= REFILL;
            end
          end
        end
        REFILL: begin
          if (bus.mem_ack) begin
            cnt <= cnt + 1'b1;
            if (last_word) begin
              valid[l_idx] <= 1'b1;
              cnt          <= '0;
              state        <= IDLE;
            end
          end
        end
        WRITE: begin
          if (bus.mem_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays: refill words, tag on the final word, write-through update.
  always_ff @(posedge clk) begin
    if (state == REFILL && bus.mem_ack) begin
      data_arr[{l_idx, cnt}] <= bus.mem_rdata;
      if (last_word) tag_arr[l_idx] <= l_tag;
    end else if (state == WRITE && bus.mem_ack && l_hit) begin
      data_arr[{l_idx, l_word}] <= l_wdata;
    end
  end

  // Outputs decoded from the current state; backing fields are zero when idle.
  always_comb begin
    bus.cpu_wait  = 1'b0;
    bus.cpu_rdata = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      IDLE: begin
        if (bus.cpu_access) begin
          if (!bus.cpu_we && c_hit) bus.cpu_rdata = data_arr[{c_idx, c_word}];
          else                      bus.cpu_wait  = 1'b1;
        end
      end
      REFILL: begin
        bus.cpu_wait = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = {l_tag, l_idx, cnt, 2'b00};
      end
      WRITE: begin
        bus.cpu_wait  = !bus.mem_ack;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {l_tag, l_idx, l_word, 2'b00};
        bus.mem_wdata = l_wdata;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_l1_dm_cache.sv
// Directed bench for l1_dm_cache with a 2-cycle-ack backing memory model.
module tb_l1_dm_cache;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  l1_dm_cache_if #(.ADDR_WIDTH(32)) bus ();

  l1_dm_cache #(
    .ADDR_WIDTH    (32),
    .NUM_SETS      (64),
    .WORDS_PER_LINE(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory: unwritten words read as addr ^ 0xA5A5_0000.
  logic [31:0] bmem [logic [31:0]];
  logic [31:0] ack_addrs [$];
  int          ack_cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mem_ack   <= 1'b0;
      bus.mem_rdata <= '0;
    end else begin
      if (bus.mem_req && bus.mem_ack) begin
        if (bus.mem_we) bmem[bus.mem_addr] = bus.mem_wdata;
        ack_addrs.push_back(bus.mem_addr);
        ack_cnt++;
      end
      bus.mem_ack   <= bus.mem_req && !bus.mem_ack;
      bus.mem_rdata <= mem_word(bus.mem_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One CPU access held until cpu_wait drops; reports the completing cycle.
  task automatic cpu_op(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output int waits, output logic a_we, output logic [31:0] a_addr,
                        output logic a_req);
    @(posedge clk); #1;
    bus.cpu_access = 1'b1;
    bus.cpu_we     = we;
    bus.cpu_addr   = addr;
    bus.cpu_wdata  = wdata;
    waits = 0;
    rdata = '0; a_we = 1'b0; a_addr = '0; a_req = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.cpu_wait) begin
        rdata  = bus.cpu_rdata;
        a_we   = bus.mem_we;
        a_addr = bus.mem_addr;
        a_req  = bus.mem_req;
        break;
      end
      waits++;
    end
    if (bus.cpu_wait) check({tag, "_timeout"}, 32'(bus.cpu_wait), 32'd0);
    @(posedge clk); #1;
    bus.cpu_access = 1'b0;
    bus.cpu_we     = 1'b0;
  endtask

  logic [31:0] rd, aaddr;
  logic        awe, areq;
  int          w;
  int          base;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ack_cnt  = 0;
    bus.cpu_access = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    reset = 1'b1;
    #22;
    check("rst_mem_req",   32'(bus.mem_req), 32'd0);
    check("rst_mem_we",    32'(bus.mem_we), 32'd0);
    check("rst_mem_addr",  bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_cpu_wait",  32'(bus.cpu_wait), 32'd0);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: cold read miss and full line refill
    ack_addrs.delete();
    cpu_op("t1", 1'b0, 32'h0000_0104, '0, rd, w, awe, aaddr, areq);
    check("t1_waits", 32'(w), 32'd9);
    check("t1_rdata", rd, 32'hA5A5_0104);
    check("t1_nacks", 32'(ack_addrs.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < ack_addrs.size()) check("t1_mem_addr", ack_addrs[i], 32'h100 + 32'(4 * i));

    // 2: hit in the freshly filled line
    base = ack_cnt;
    cpu_op("t2", 1'b0, 32'h0000_0108, '0, rd, w, awe, aaddr, areq);
    check("t2_waits", 32'(w), 32'd0);
    check("t2_rdata", rd, 32'hA5A5_0108);
    check("t2_mem_req", 32'(areq), 32'd0);
    check("t2_no_acks", 32'(ack_cnt - base), 32'd0);

    // 3: write hit, then read back the updated word
    base = ack_cnt;
    cpu_op("t3w", 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, rd, w, awe, aaddr, areq);
    check("t3_waits", 32'(w), 32'd2);
    check("t3_ack_we", 32'(awe), 32'd1);
    check("t3_ack_addr", aaddr, 32'h104);
    cpu_op("t3r", 1'b0, 32'h0000_0104, '0, rd, w, awe, aaddr, areq);
    check("t3_nacks", 32'(ack_cnt - base), 32'd1);
    check("t3r_waits", 32'(w), 32'd0);
    check("t3r_rdata", rd, 32'hDEAD_BEEF);

    // 4: write miss does not allocate
    cpu_op("t4w", 1'b1, 32'h0000_2000, 32'h1234_5678, rd, w, awe, aaddr, areq);
    check("t4_waits", 32'(w), 32'd2);
    check("t4_ack_addr", aaddr, 32'h2000);
    cpu_op("t4r", 1'b0, 32'h0000_2000, '0, rd, w, awe, aaddr, areq);
    check("t4r_waits", 32'(w), 32'd9);
    check("t4r_rdata", rd, 32'h1234_5678);

    // 5: conflict eviction in set 0x10
    cpu_op("t5a", 1'b0, 32'h0000_0104, '0, rd, w, awe, aaddr, areq);
    check("t5a_waits", 32'(w), 32'd0);
    cpu_op("t5b", 1'b0, 32'h0000_0504, '0, rd, w, awe, aaddr, areq);
    check("t5b_waits", 32'(w), 32'd9);
    check("t5b_rdata", rd, 32'hA5A5_0504);
    cpu_op("t5c", 1'b0, 32'h0000_0104, '0, rd, w, awe, aaddr, areq);
    check("t5c_waits", 32'(w), 32'd9);
    check("t5c_rdata", rd, 32'hDEAD_BEEF);

    // 6: reset after two refill acks, then a full refill of the same line
    base = ack_cnt;
    @(posedge clk); #1;
    bus.cpu_access = 1'b1;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = 32'h0000_0300;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (ack_cnt - base >= 2) break;
    end
    if (ack_cnt - base < 2) check("t6_ack_wait", 32'(ack_cnt - base), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check("t6_mem_req", 32'(bus.mem_req), 32'd0);
    check("t6_mem_addr", bus.mem_addr, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.cpu_access = 1'b0;
    ack_addrs.delete();
    cpu_op("t6", 1'b0, 32'h0000_0300, '0, rd, w, awe, aaddr, areq);
    check("t6_waits", 32'(w), 32'd9);
    check("t6_rdata", rd, 32'hA5A5_0300);
    check("t6_nacks", 32'(ack_addrs.size()), 32'd4);
    if (ack_addrs.size() > 0) check("t6_first_addr", ack_addrs[0], 32'h300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
